// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor that resolves one GROUP-bit lookahead group per stage.
// Optional signed-overflow output when CLA_OVF_EN is defined.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NG = WIDTH / GROUP;

    generate
        if (GROUP < 1 || (WIDTH % GROUP) != 0) begin : g_bad_cfg
            $fatal(1, "pipelined_cla_adder: WIDTH must be a non-zero multiple of GROUP");
        end
    endgenerate

    // Each carry is a sum of products of g/p and the group carry-in, never rippled from the previous bit.
    function automatic logic [GROUP:0] lookahead(input logic [GROUP-1:0] g,
                                                 input logic [GROUP-1:0] p,
                                                 input logic             c0);
        logic [GROUP:0] c;
        logic           term;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < GROUP; i++) begin
            term = c0;
            for (int j = 0; j <= i; j++) term &= p[j];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term &= p[m];
                c[i+1] |= term;
            end
        end
        return c;
    endfunction

    // Index k of v_q/c_q/a_q/b_q is the input side of stage k; s_q[k] holds the sum after stage k.
    logic             v_q [0:NG];
    logic             c_q [0:NG];
    logic [WIDTH-1:0] a_q [0:NG-1];
    logic [WIDTH-1:0] b_q [0:NG-1];
    logic [WIDTH-1:0] s_q [0:NG-1];

    logic [WIDTH-1:0] s_nxt  [0:NG-1];
    logic             co_nxt [0:NG-1];
    logic             msb_cin;
    logic             adv;

    assign out_valid = v_q[NG];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign sum       = s_q[NG-1];
    assign carryout  = c_q[NG];

    always_comb begin
        logic [GROUP-1:0] gg;
        logic [GROUP-1:0] gp;
        logic [GROUP:0]   cc;
        logic [GROUP:0]   cg;
        gg      = '0;
        gp      = '0;
        cc      = '0;
        cg      = '0;
        msb_cin = 1'b0;
        for (int k = 0; k < NG; k++) begin
            gg = a_q[k][k*GROUP +: GROUP] & b_q[k][k*GROUP +: GROUP];
            gp = a_q[k][k*GROUP +: GROUP] ^ b_q[k][k*GROUP +: GROUP];
            cc = lookahead(gg, gp, c_q[k]);
            // Group generate is the lookahead carry-out with a zero carry-in.
            cg = lookahead(gg, gp, 1'b0);
            co_nxt[k] = cg[GROUP] | ((&gp) & c_q[k]);
            s_nxt[k]  = (k == 0) ? '0 : s_q[(k == 0) ? 0 : k - 1];
            s_nxt[k][k*GROUP +: GROUP] = gp ^ cc[GROUP-1:0];
            if (k == NG - 1) msb_cin = cc[GROUP-1];
        end
    end

`ifdef CLA_OVF_EN
    logic ovf_q;
    assign ovf = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the skew/sum arrays are small pipeline registers, so clearing them on reset is cheap and keeps outputs at zero.
            for (int k = 0; k <= NG; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
            end
            for (int k = 0; k < NG; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
`ifdef CLA_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else if (adv) begin
            v_q[0] <= in_valid;
            c_q[0] <= sub | carryin;
            a_q[0] <= a;
            b_q[0] <= b ^ {WIDTH{sub}};
            for (int k = 0; k < NG; k++) begin
                v_q[k+1] <= v_q[k];
                c_q[k+1] <= co_nxt[k];
                s_q[k]   <= s_nxt[k];
            end
            for (int k = 1; k < NG; k++) begin
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
            end
`ifdef CLA_OVF_EN
            ovf_q <= msb_cin ^ co_nxt[NG-1];
`endif
        end
    end

`ifndef CLA_OVF_EN
    logic unused_ovf;
    assign unused_ovf = msb_cin;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: vector table, scoreboard, backpressure, bubbles and mid-flight reset.
module tb_pipelined_cla_adder;

    localparam int W  = 16;
    localparam int G  = 4;
    localparam int NG = W / G;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carryin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carryout;
`ifdef CLA_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .carryin  (carryin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .carryout (carryout)
`ifdef CLA_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
        bit           chk_lat;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   pushes = 0;
    int   pops = 0;
    bit   lat_mode = 1'b1;
    bit   stim_done = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                   input logic vcin, input logic vsub);
        exp_t       e;
        logic [W-1:0] beff;
        logic [W:0]   full;
        beff   = vsub ? ~vb : vb;
        full   = {1'b0, va} + {1'b0, beff} + {{W{1'b0}}, (vsub ? 1'b1 : vcin)};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (va[W-1] == beff[W-1]) && (full[W-1] != va[W-1]);
        e.acc  = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    // Output side of the scoreboard: compare whenever a result is handed over.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_output", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                pops++;
                check("sum", sum, e.sum);
                check("carryout", carryout, e.cout);
`ifdef CLA_OVF_EN
                check("ovf", ovf, e.ovf);
`endif
                if (e.chk_lat) check("latency", cyc - e.acc, NG);
            end
        end
    end

    // Presents one operation from posedge+1 and returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vcin,
                        input logic vsub, input logic [W-1:0] esum, input logic ecout,
                        input logic eovf);
        exp_t e;
        bit   done;
        done     = 1'b0;
        a        = va;
        b        = vb;
        carryin  = vcin;
        sub      = vsub;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            done = (in_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        if (!done) begin
            check("accept_timeout", {31'b0, done}, 1);
        end else begin
            e.sum     = esum;
            e.cout    = ecout;
            e.ovf     = eovf;
            e.acc     = cyc;
            e.chk_lat = lat_mode;
            sb.push_back(e);
            pushes++;
        end
    endtask

    task automatic drain(input int max_cycles);
        for (int t = 0; t < max_cycles && sb.size() != 0; t++) @(posedge clk);
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t       e;
        logic [W-1:0] held;
        bit         seen;

        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[2]  = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[3]  = '{16'hF0F0, 16'h0F0F, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[4]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[6]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[7]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[8]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[9]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[10] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[11] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

        // Reset held for two edges with a pending operand set.
        rst = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h4321;
        carryin = 1'b1; sub = 1'b0; out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_out_valid", out_valid, 0);
            check("rst_sum", sum, 0);
            check("rst_carryout", carryout, 0);
`ifdef CLA_OVF_EN
            check("rst_ovf", ovf, 0);
`endif
        end
        rst = 1'b0; in_valid = 1'b0;
        repeat (NG) begin
            @(posedge clk); #1;
            check("post_rst_out_valid", out_valid, 0);
            check("post_rst_sum", sum, 0);
            check("post_rst_carryout", carryout, 0);
        end

        // Directed vectors, back-to-back, exact latency checked per result.
        lat_mode = 1'b1;
        for (int i = 0; i < 12; i++)
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                 vecs[i].sum, vecs[i].cout, vecs[i].ovf);
        in_valid = 1'b0;
        drain(50);

        // Backpressure: fill the pipeline with out_ready low, stall, then release.
        lat_mode  = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 7; i++) begin
                    e = model(16'h1000 * i[15:0] + 16'h00A5, 16'h0F0F + i[15:0], i[0], i[1]);
                    send(16'h1000 * i[15:0] + 16'h00A5, 16'h0F0F + i[15:0], i[0], i[1],
                         e.sum, e.cout, e.ovf);
                end
                in_valid = 1'b0;
            end
            begin
                seen = 1'b0;
                for (int t = 0; t < 50 && !seen; t++) begin
                    @(negedge clk);
                    seen = (out_valid === 1'b1);
                end
                check("bp_fill_seen", {31'b0, seen}, 1);
                held = sum;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready", in_ready, 0);
                    check("bp_out_valid_held", out_valid, 1);
                    check("bp_sum_held", sum, held);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain(50);

        // Random stream with input bubbles and random output stalls.
        stim_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [W-1:0] ra;
                    logic [W-1:0] rb;
                    logic         rc;
                    logic         rs;
                    ra = W'($urandom);
                    rb = W'($urandom);
                    rc = 1'($urandom);
                    rs = 1'($urandom);
                    e  = model(ra, rb, rc, rs);
                    send(ra, rb, rc, rs, e.sum, e.cout, e.ovf);
                    in_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                end
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain(100);

        // Reset two cycles after an accept discards the in-flight operation.
        lat_mode  = 1'b1;
        out_ready = 1'b1;
        e = model(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h1111, 16'h2222, 1'b0, 1'b0, e.sum, e.cout, e.ovf);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        pushes -= sb.size();
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (NG + 2) begin
            @(negedge clk);
            check("flush_out_valid", out_valid, 0);
        end
        @(posedge clk); #1;
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        in_valid = 1'b0;
        drain(50);
        check("pop_count", pops, pushes);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides.
- Operands are split into GROUP-bit lookahead groups; one group is resolved per pipeline stage, and the group carry is registered between stages.
- Any WIDTH that is a multiple of GROUP is supported. Throughput is one operation per cycle.
- Successor to the fixed 4-bit combinational CLA. It serves datapath units that need wide adds at high clock rates.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of GROUP.
- GROUP, 4, lookahead group width; each group uses internal generate/propagate and group G/P.
- NG, WIDTH/GROUP (derived, localparam), number of pipeline stages, which is also the latency.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand set present
- in_ready  output  1  block can accept this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- carryin  input  1  carry-in; used only when sub=0
- sub  input  1  0: a+b+carryin; 1: a-b (a+~b+1)
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts
- sum  output  WIDTH  result
- carryout  output  1  carry out of the MSB; for sub, 1 means no borrow
- ovf  output  1  signed overflow (CLA_OVF_EN only)

Behaviour:
- Reset: one clk edge with rst=1 clears every stage valid bit and all skew/sum registers. After reset: out_valid=0, sum=0, carryout=0, ovf=0.
- rst has priority over every other input and may be asserted mid-operation. In-flight operations are discarded and never appear at the output.
- Accept: a transfer happens when in_valid && in_ready at a rising edge. The effective B is b^{WIDTH{sub}}, and the effective cin is sub ? 1 : carryin. Both are captured together.
- Stage k (0..NG-1) computes group k from the registered carry c_k (c_0 = effective cin).
  - It uses 4-bit-style lookahead inside the group: c_{i+1} = g_i | p_i&c_i, expanded as sum-of-products and not rippled.
  - Group carry out = G | P&c_k.
- Skew registers:
  - Upper operand groups are delayed until their stage.
  - Completed lower sum groups are delayed so all groups align at the output.
- Latency: exactly NG cycles from the accept edge to out_valid=1 with no stalls. For the defaults, NG=4.
- Stall: the whole pipeline advances only when adv = !out_valid || out_ready.
  - in_ready = adv, which is combinational from out_valid and out_ready.
  - When adv=0, every stage holds. sum, carryout and ovf stay stable, and no bubble is inserted or dropped.
- Bubbles: stages with valid=0 still advance when adv=1, and out_valid reflects the last stage's valid bit.
- Ordering: results leave strictly in acceptance order, and none are lost or duplicated.
- Width/wrap: sum is (a ± b + cin) mod 2^WIDTH, and carryout is bit WIDTH of the full result.
  - Add mode: carryout=1 on unsigned overflow.
  - Sub mode: carryout=0 when a < b (unsigned).
- Simultaneous events: an accept and an output handshake on the same edge are both honoured, giving full throughput.
- Elaboration: WIDTH % GROUP != 0 or GROUP < 1 is a fatal error.

Optional Feature:
- Macro: CLA_OVF_EN.
- Defined: ovf is a port. ovf = carry into MSB XOR carryout, i.e. two's-complement overflow of the effective add. It is registered and aligned with sum, and reset to 0.
- Undefined: the ovf port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset: hold rst for 2 cycles with in_valid=1 -> out_valid=0, sum=0x0000, carryout=0 throughout and for NG cycles afterwards.
- Carry chain: a=0xFFFF, b=0x0001, carryin=0, sub=0, out_ready=1 -> 4 cycles later sum=0x0000, carryout=1. Also a=0x0000, b=0x0000, carryin=1 -> sum=0x0001, carryout=0.
- Back-to-back and ordering: accept (0x1234+0x1111), (0xF0F0+0x0F0F, cin=1), (0x8000+0x8000) on consecutive cycles -> results 0x2345/0, 0x0000/1, 0x0000/1 on three consecutive cycles, starting at cycle 4.
- Backpressure: with the pipeline full, drop out_ready for 3 cycles -> in_ready=0, sum/out_valid held constant. Raise out_ready -> remaining results drain in order, one per cycle, with none lost or duplicated.
- Subtract: a=0x0005, b=0x0007, sub=1, carryin=1 (ignored) -> sum=0xFFFE, carryout=0. a=0x0007, b=0x0005 -> sum=0x0002, carryout=1.
- Reset mid-flight plus overflow (CLA_OVF_EN defined):
  - Accept 0x7FFF+0x0001 -> sum=0x8000, ovf=1.
  - 0x8000-0x0001 -> sum=0x7FFF, ovf=1.
  - Assert rst for one cycle 2 cycles after an accept -> that result never appears (out_valid stays 0).
